ram_rd_checker: RTL
===================

RAM_RD_CHECKER -- requirements
Module: ram_rd_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 2, RAM read latency in clocks (legal range 1..4).
REQ-004 SHALL have port rdclk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a full read sweep.
REQ-007 SHALL have port q  input  DATA_W  RAM read-port data.
REQ-008 SHALL have port rd_addr  output  ADDR_W  RAM read address, registered.
REQ-009 SHALL have port rd_en  output  1  RAM read enable, registered.
REQ-010 SHALL have port busy  output  1  high from sweep start until done.
REQ-011 SHALL have port done  output  1  level; high when a sweep has completed, until the next start.
REQ-012 SHALL have port pass  output  1  valid when done=1; high iff err_cnt=0.
REQ-013 SHALL have port err_cnt  output  ADDR_W+1  mismatch count for the current or last sweep.
REQ-014 SHALL have port first_err_addr  output  ADDR_W  address of the first mismatch.
REQ-015 SHALL have port first_err_data  output  DATA_W  q value read at the first mismatch.

Function
REQ-016 SHALL check that q equals the expected pattern addr[DATA_W-1:0], where addr is the RAM address that was read; this is the pattern the upstream writer stores.
REQ-017 SHALL implement an FSM with states IDLE, READ, DRAIN and DONE.
REQ-018 IDLE or DONE, start=1 at edge k: go to READ; rd_en=1, rd_addr=0, busy=1, done=0, pass=0, and err_cnt and first-error registers cleared, all after edge k.
REQ-019 READ: rd_addr SHALL increment by 1 at each edge; after edge k+1023 rd_addr=1023; at edge k+1024 go to DRAIN with rd_en=0 and rd_addr held at 1023, with no wrap.
REQ-020 Compare timing: address n, presented after edge k+n, SHALL be compared with q sampled at edge k+n+RD_LAT, using an RD_LAT-deep valid/address delay line.
REQ-021 DRAIN SHALL last exactly RD_LAT cycles, then go to DONE; done=1 and busy=0 after edge k+1024+RD_LAT.
REQ-022 pass SHALL be registered as (err_cnt==0), updated on entry to DONE.
REQ-023 Each mismatch SHALL increment err_cnt by 1, saturating at all-ones.
REQ-024 start while busy=1 SHALL be ignored, with no restart and no counter change.
REQ-025 DONE SHALL hold all outputs stable until the next start.

Reset
REQ-026 rst=1 SHALL, asynchronously, force state IDLE, and force rd_addr, rd_en, busy, done, pass, err_cnt, first_err_addr, first_err_data and the delay line to 0.
REQ-027 rst asserted mid-sweep SHALL abort the sweep; no done and no compare of in-flight reads occur after release.
REQ-028 rst and start in the same cycle: reset SHALL win.

Configuration
REQ-029 Macro RAM_CHK_FIRST_ERR_EN, when defined, SHALL capture first_err_addr and first_err_data on the first mismatch of a sweep (when err_cnt is 0) and hold them until the next start or reset.
REQ-030 Without RAM_CHK_FIRST_ERR_EN, first_err_addr and first_err_data SHALL be constant 0 with no capture registers; all other behaviour is identical.

Verification
REQ-031 RAM model with RD_LAT=2 preloaded with addr[7:0]; start pulse -> 1024 reads of addresses 0..1023; done=1 after 1026 cycles; pass=1, err_cnt=0.
REQ-032 Same setup but word 300 = 0x00 (expected 0x2C), macro defined -> err_cnt=1, pass=0, first_err_addr=300, first_err_data=0x00.
REQ-033 Words 5 and 900 corrupted, macro undefined -> err_cnt=2, pass=0, first_err_addr=0, first_err_data=0.
REQ-034 start re-pulsed at rd_addr=100 -> ignored; sweep completes at the original time, with 1024 reads total.
REQ-035 rst pulsed when rd_addr=500 -> all outputs 0 immediately; after release no done until a new start, and a new start gives pass=1.
REQ-036 Two back-to-back sweeps, the first with 3 errors and the second clean -> the second start clears err_cnt; final err_cnt=0, pass=1.

Source files
------------

// File: rtl/ram_rd_checker.sv
// ram_rd_checker: sweeps every address of a RAM read port once per start
// request and checks that each word holds its own address as data
// (addr[DATA_W-1:0]). It reports the mismatch count, pass/fail and, if
// built with RAM_CHK_FIRST_ERR_EN, the address and data of the first mismatch.
// Without RAM_CHK_FIRST_ERR_EN the first-error outputs are tied to zero.
module ram_rd_checker #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              rdclk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_drainCnt;
    logic                w_tapVld;
    logic [ADDR_W-1:0]   w_tapAddr;
    logic                w_startAcc;
    logic                w_mismatch;

    // The registered rd_en/rd_addr pair is the first stage of the read
    // delay line; RD_LAT-1 further stages line each address up with the
    // q sample that answers it.
    generate
        if (RD_LAT == 1) begin : g_noDly
            assign w_tapVld  = rd_en;
            assign w_tapAddr = rd_addr;
        end else begin : g_dly
            logic              r_vldDly  [RD_LAT-1];
            logic [ADDR_W-1:0] r_addrDly [RD_LAT-1];

            // Shift issued read requests along so in-flight reads are
            // forgotten on reset.
            always_ff @(posedge rdclk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        r_vldDly[i]  <= 1'b0;
                        r_addrDly[i] <= '0;
                    end
                end else begin
                    r_vldDly[0]  <= rd_en;
                    r_addrDly[0] <= rd_addr;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        r_vldDly[i]  <= r_vldDly[i-1];
                        r_addrDly[i] <= r_addrDly[i-1];
                    end
                end
            end

            assign w_tapVld  = r_vldDly[RD_LAT-2];
            assign w_tapAddr = r_addrDly[RD_LAT-2];
        end
    endgenerate

    assign w_startAcc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch = w_tapVld && (q != DATA_W'(w_tapAddr));

    // Sweep sequencing, registered status outputs and the mismatch counter.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_drainCnt <= 2'd0;
            rd_addr    <= '0;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            if (w_startAcc) begin
                err_cnt <= '0;
            end else if (w_mismatch && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end

            case (r_state)
                IDLE, DONE: begin
                    if (w_startAcc) begin
                        r_state <= READ;
                        rd_addr <= '0;
                        rd_en   <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_addr == '1) begin
                        r_state    <= DRAIN;
                        rd_en      <= 1'b0;
                        r_drainCnt <= 2'd0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drainCnt == 2'(RD_LAT - 1)) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt == '0);
                    end else begin
                        r_drainCnt <= r_drainCnt + 2'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RAM_CHK_FIRST_ERR_EN
    // Latch the location and data of the first mismatch of each sweep.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (w_startAcc) begin
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (w_mismatch && (err_cnt == '0)) begin
            first_err_addr <= w_tapAddr;
            first_err_data <= q;
        end
    end
`else
    assign first_err_addr = '0;
    assign first_err_data = '0;
`endif

endmodule
